fifo_rd_packer: RTL
===================

Name: fifo_rd_packer

Overview:
Single-clock consumer for the read port of the dual-clock FIFO (r_ok/rdata/r_en side), running in the rclk domain. It drains DSIZE-bit words from the FIFO and packs RATIO consecutive words into one wide output beat, which it presents on a valid/ready interface to downstream logic. A flush input forces a partial beat out, with a keep mask and a last flag. This block is the reader counterpart to the FIFO's write-side producer.

Parameters:
DSIZE, 8, FIFO word width; must match the FIFO DSIZE.
RATIO, 4, words per output beat; 2..16.
CSIZE, 16, width of the beat counter.

Ports:
rclk  input  1  clock; all logic is on the rising edge.
rst_n  input  1  reset, asynchronous, active-low.
r_ok  input  1  FIFO read-valid; rdata holds a word while high.
rdata  input  DSIZE  FIFO read data.
r_en  output  1  FIFO read enable; a word is consumed when r_ok and r_en are both high at a rising edge.
flush  input  1  one-cycle request to emit the partial beat.
out_valid  output  1  output beat valid.
out_ready  input  1  downstream accept.
out_data  output  DSIZE*RATIO  packed beat; the first word received sits in bits [DSIZE-1:0].
out_keep  output  RATIO  bit i is 1 when word slot i holds data.
out_last  output  1  beat was closed by flush.
beat_cnt  output  CSIZE  number of beats accepted downstream; wraps modulo 2^CSIZE.

Behaviour:
- Reset values (asynchronous): out_valid=0, out_data=0, out_keep=0, out_last=0, beat_cnt=0, internal word count wcnt=0, assembly register=0, flush_pend=0.
- Handshakes:
  - take = r_ok & r_en.
  - out_fire = out_valid & out_ready.
  - r_en is combinational: r_en = (~out_valid | out_ready) & ~flush_pend. After reset, r_en=1.
- Word accept (on take):
  - rdata is written to slot wcnt of the assembly register and keep bit wcnt is set.
  - If wcnt = RATIO-1, the beat closes and wcnt returns to 0; otherwise wcnt increments.
- Beat close:
  - On the same edge, out_data and out_keep are loaded from the assembly register including the word just taken.
  - out_valid is set to 1 and out_last to 0.
  - The assembly register and its keep bits clear.
  - Latency: the out_valid rise is visible in the cycle after the edge that takes the RATIO-th word.
- Output hold: while out_valid=1 and out_ready=0, out_data, out_keep and out_last stay stable and r_en=0.
- On out_fire:
  - beat_cnt increments.
  - out_valid clears unless a new beat closes on the same edge. Back-to-back beats are allowed: take and out_fire on the same edge is legal.
- Flush:
  - flush=1 with a partial beat present closes the beat at that edge with out_last=1.
    - "Partial beat present" means wcnt>0, or a take on that edge.
    - Any word taken on that edge is included.
    - out_keep shows only the filled slots; unfilled out_data slots are 0.
    - wcnt returns to 0.
  - Flush with wcnt=0 and no take: ignored; no empty beat is ever emitted.
  - Flush arriving while out_valid=1 and out_ready=0: the flush sets flush_pend.
    - A take on that edge is impossible, because r_en=0.
    - On the edge where the pending beat fires, if wcnt>0 the partial beat closes with out_last=1; flush_pend clears either way.
  - If a take fills slot RATIO-1 on a flush edge, a full beat is emitted with out_last=1.
- States: IDLE/FILL are implicit in wcnt; HOLD is out_valid & ~out_ready; FLUSH_PEND is flush_pend=1.
- Reset mid-operation discards the partial beat and any pending output immediately; no data is retained.
- rdata is sampled only when take=1; its value is don't-care otherwise.

Test Plan:
- DSIZE=8, RATIO=4, out_ready=1; FIFO supplies 0x11,0x22,0x33,0x44 back-to-back -> one beat out_data=0x44332211, out_keep=4'b1111, out_last=0; beat_cnt=1; out_valid high exactly one cycle.
- Feed 0xA1,0xA2, then pulse flush with r_ok=0 -> beat out_data=0x0000A2A1, out_keep=4'b0011, out_last=1; a next flush pulse produces no beat.
- out_ready=0 after the first full beat; FIFO still has 0x55..0x58 -> r_en=0 and out_data held at 0x44332211 for 10 cycles; on release, the next beat is 0x58575655 with no word lost or duplicated.
- Flush on the same edge as the take of the 3rd word 0x0C (after 0x0A,0x0B) -> out_data=0x000C0B0A, out_keep=4'b0111, out_last=1.
- Pulse flush while a beat is held and wcnt=0, then release out_ready -> no extra beat, flush_pend clears, and r_en returns to 1.
- Assert rst_n=0 after 2 words accepted -> all outputs 0 immediately; after release, a fresh 4 words give a beat containing only the new words.

Source files
------------

// File: rtl/fifo_rd_packer_if.sv
// FIFO read-port and packed-beat output bundle for fifo_rd_packer.
// master = packer side (drives r_en and the beat), slave = FIFO/downstream side.
interface fifo_rd_packer_if #(
    parameter int DSIZE = 8,
    parameter int RATIO = 4
);
    logic                   r_ok;
    logic [DSIZE-1:0]       rdata;
    logic                   r_en;
    logic                   out_valid;
    logic                   out_ready;
    logic [DSIZE*RATIO-1:0] out_data;
    logic [RATIO-1:0]       out_keep;
    logic                   out_last;

    modport master (
        input  r_ok, rdata, out_ready,
        output r_en, out_valid, out_data, out_keep, out_last
    );

    modport slave (
        output r_ok, rdata, out_ready,
        input  r_en, out_valid, out_data, out_keep, out_last
    );
endinterface

// File: rtl/fifo_rd_packer.sv
// Packs RATIO FIFO words into one beat; out_valid rises the cycle after the RATIO-th take.
// Backpressure: r_en drops while a beat is held (out_valid & ~out_ready) or a flush is pending.
module fifo_rd_packer #(
    parameter int DSIZE = 8,
    parameter int RATIO = 4,
    parameter int CSIZE = 16
) (
    input  logic             rclk,
    input  logic             rst_n,
    input  logic             flush,
    fifo_rd_packer_if.master bus,
    output logic [CSIZE-1:0] beat_cnt
);
    localparam int WW = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [WW-1:0] LAST_SLOT = WW'(RATIO - 1);

    logic [WW-1:0]          wcnt;
    logic [DSIZE*RATIO-1:0] asm_dat;
    logic [RATIO-1:0]       asm_keep;
    logic                   flush_pend;
    logic                   out_valid_q;
    logic [DSIZE*RATIO-1:0] out_data_q;
    logic [RATIO-1:0]       out_keep_q;
    logic                   out_last_q;

    logic                   slot_free;
    logic                   take;
    logic                   out_fire;
    logic                   close_full;
    logic                   close_flush;
    logic [DSIZE*RATIO-1:0] asm_dat_nxt;
    logic [RATIO-1:0]       asm_keep_nxt;

    assign slot_free = ~out_valid_q | bus.out_ready;
    assign bus.r_en  = slot_free & ~flush_pend;
    assign take      = bus.r_ok & bus.r_en;
    assign out_fire  = out_valid_q & bus.out_ready;

    // A flush can only close a beat when the output register is free this edge;
    // a pending flush closes on the edge its blocking beat fires.
    assign close_full  = take & (wcnt == LAST_SLOT);
    assign close_flush = slot_free & (flush | flush_pend) & ((wcnt != '0) | take);

    always_comb begin
        asm_dat_nxt  = asm_dat;
        asm_keep_nxt = asm_keep;
        if (take) begin
            asm_dat_nxt[wcnt*DSIZE +: DSIZE] = bus.rdata;
            asm_keep_nxt[wcnt]               = 1'b1;
        end
    end

    always_ff @(posedge rclk or negedge rst_n) begin
        if (!rst_n) begin
            wcnt        <= '0;
            asm_dat     <= '0;
            asm_keep    <= '0;
            flush_pend  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_keep_q  <= '0;
            out_last_q  <= 1'b0;
            beat_cnt    <= '0;
        end else begin
            if (out_fire) begin
                beat_cnt    <= beat_cnt + 1'b1;
                out_valid_q <= 1'b0;
            end

            if (close_full || close_flush) begin
                out_data_q  <= asm_dat_nxt;
                out_keep_q  <= asm_keep_nxt;
                out_last_q  <= close_flush;
                out_valid_q <= 1'b1;
                asm_dat     <= '0;
                asm_keep    <= '0;
                wcnt        <= '0;
            end else begin
                asm_dat  <= asm_dat_nxt;
                asm_keep <= asm_keep_nxt;
                if (take) wcnt <= wcnt + 1'b1;
            end

            if (out_fire)
                flush_pend <= 1'b0;
            else if (flush && out_valid_q && !bus.out_ready)
                flush_pend <= 1'b1;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_keep  = out_keep_q;
    assign bus.out_last  = out_last_q;
endmodule
